// File: rtl/adder_sum_accumulator.sv
// Batch accumulator for 2-bit full-adder results: sums N_SAMPLES values of {cout,sum}
// into a saturating ACC_W-bit register and hands the total off over valid/ready.
module adder_sum_accumulator #(
    parameter int unsigned ACC_W     = 8,
    parameter int unsigned N_SAMPLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       sum,
    input  logic             cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] total,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(N_SAMPLES + 1);
    localparam int unsigned SUM_W = ACC_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic [ACC_W-1:0] v_ext;
    logic [SUM_W-1:0] sum_ext;
    logic [ACC_W-1:0] sat_sum;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;
    logic             last;

    // Handshake is combinational so a source can stream one result per cycle.
    assign in_ready = (state != DONE) && !clear;
    assign accept   = in_valid && in_ready;

    // One extra bit catches the carry that triggers saturation.
    assign v_ext   = ACC_W'({cout, sum});
    assign sum_ext = SUM_W'(acc) + SUM_W'(v_ext);
    assign sat_sum = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
    assign cnt_inc = cnt + CNT_W'(1);
    assign last    = (cnt_inc == CNT_W'(N_SAMPLES));

    // Batch FSM; total mirrors the value acc takes on every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            total     <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            total     <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc      <= v_ext;
                        total    <= v_ext;
                        cnt      <= CNT_W'(1);
                        overflow <= 1'b0;
                        if (N_SAMPLES == 32'd1) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            state <= ACCUM;
                            busy  <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc      <= sat_sum;
                        total    <= sat_sum;
                        cnt      <= cnt_inc;
                        overflow <= overflow | sum_ext[ACC_W];
                        if (last) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            busy      <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        acc       <= '0;
                        cnt       <= '0;
                        total     <= '0;
                        overflow  <= 1'b0;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    acc       <= '0;
                    cnt       <= '0;
                    total     <= '0;
                    overflow  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Scoreboarded bench for adder_sum_accumulator: an ACC_W=8 and an ACC_W=4 copy share
// one stimulus stream; a separate N_SAMPLES=1 copy covers the single-sample batch.
module tb_adder_sum_accumulator;

    localparam int N = 4;

    typedef struct {
        int t8;
        int o8;
        int t4;
        int o4;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic [1:0] s_sum;
    logic       s_cout;
    logic       out_ready;

    logic       in_ready, out_valid, overflow, busy;
    logic [7:0] total;
    logic       in_ready4, out_valid4, overflow4, busy4;
    logic [3:0] total4;

    logic       iv1;
    logic [1:0] s_sum1;
    logic       s_cout1;
    logic       in_ready1, out_valid1, overflow1, busy1;
    logic [2:0] total1;

    int checks   = 0;
    int failures = 0;

    int   m_n, m_sum;
    bit   m_done, m_acc;
    exp_t exp_q[$];
    exp_t cur;
    bit   prev_v;

    always #5 clk = ~clk;

    adder_sum_accumulator #(.ACC_W(8), .N_SAMPLES(N)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .sum(s_sum), .cout(s_cout), .out_valid(out_valid), .out_ready(out_ready),
        .total(total), .overflow(overflow), .busy(busy));

    adder_sum_accumulator #(.ACC_W(4), .N_SAMPLES(N)) dut4 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready4),
        .sum(s_sum), .cout(s_cout), .out_valid(out_valid4), .out_ready(out_ready),
        .total(total4), .overflow(overflow4), .busy(busy4));

    adder_sum_accumulator #(.ACC_W(3), .N_SAMPLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(1'b0), .in_valid(iv1), .in_ready(in_ready1),
        .sum(s_sum1), .cout(s_cout1), .out_valid(out_valid1), .out_ready(1'b1),
        .total(total1), .overflow(overflow1), .busy(busy1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Reference: a batch is just the plain sum of N accepted values, clipped to the width.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n = 0; m_sum = 0; m_done = 0; m_acc = 0;
        end else begin
            m_acc = 0;
            if (clear) begin
                m_n = 0; m_sum = 0; m_done = 0;
            end else if (m_done) begin
                if (out_ready) m_done = 0;
            end else if (in_valid) begin
                m_acc = 1;
                m_sum += int'({s_cout, s_sum});
                m_n++;
                if (m_n == N) begin
                    exp_q.push_back('{t8: sat(m_sum, 255), o8: int'(m_sum > 255),
                                      t4: sat(m_sum, 15),  o4: int'(m_sum > 15)});
                    m_done = 1; m_n = 0; m_sum = 0;
                end
            end
        end
    end

    // Monitor: pops an expected total whenever the DUT raises out_valid.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", 32'(in_ready), 32'(!m_done && !clear));
            chk("in_ready4", 32'(in_ready4), 32'(!m_done && !clear));
            chk("busy", 32'(busy), 32'(!m_done && m_n > 0));
            chk("out_valid", 32'(out_valid), 32'(m_done));
            chk("out_valid4", 32'(out_valid4), 32'(m_done));
            if (out_valid && !prev_v) begin
                if (exp_q.size() == 0) chk("unexpected_total", 32'd1, 32'd0);
                else cur = exp_q.pop_front();
            end
            if (m_done) begin
                chk("total", 32'(total), 32'(cur.t8));
                chk("overflow", 32'(overflow), 32'(cur.o8));
                chk("total4", 32'(total4), 32'(cur.t4));
                chk("overflow4", 32'(overflow4), 32'(cur.o4));
            end else begin
                chk("run_total", 32'(total), 32'(sat(m_sum, 255)));
                chk("run_total4", 32'(total4), 32'(sat(m_sum, 15)));
                chk("run_overflow4", 32'(overflow4), 32'(m_sum > 15));
            end
            prev_v = out_valid;
        end else begin
            prev_v = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        bit got = 0;
        s_sum    = 2'(v);
        s_cout   = v[2];
        in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            step();
            if (m_acc) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        int a;
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; s_sum = 2'd0; s_cout = 1'b0;
        out_ready = 1'b0; iv1 = 1'b0; s_sum1 = 2'd0; s_cout1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_total", 32'(total), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // Reset mid-batch, then a clean batch of ones.
        out_ready = 1'b1;
        send(5); send(3);
        #3 rst_n = 1'b0;
        #1;
        chk("midreset_total", 32'(total), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        step();
        rst_n = 1'b1;
        repeat (4) send(1);
        step();

        // Back-to-back full batch, held in DONE under backpressure with a pending input.
        out_ready = 1'b0;
        send(6); send(6); send(6); send(2);
        s_sum = 2'd3; s_cout = 1'b1; in_valid = 1'b1;
        repeat (5) step();
        out_ready = 1'b1;
        send(1); send(0); send(2); send(3);
        repeat (2) step();
        send(6); send(6); send(6); send(6);
        repeat (2) step();

        // Clear collides with a valid sample.
        send(2); send(5);
        clear = 1'b1; in_valid = 1'b1; s_sum = 2'd0; s_cout = 1'b1;
        step();
        clear = 1'b0; in_valid = 1'b0;
        repeat (4) send(1);
        repeat (2) step();

        // Randomized traffic with gaps, backpressure and rare clears.
        for (int c = 0; c < 800; c++) begin
            a         = int'($urandom_range(0, 7));
            s_sum     = 2'(a);
            s_cout    = a[2];
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            clear     = ($urandom_range(0, 39) == 0);
            step();
        end
        clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) step();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        // Single-sample batches: out_valid and in_ready alternate with out_ready tied high.
        @(negedge clk);
        iv1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a       = int'($urandom_range(0, 7));
            s_sum1  = 2'(a);
            s_cout1 = a[2];
            @(negedge clk);
            chk("n1_out_valid", 32'(out_valid1), 32'd1);
            chk("n1_total", 32'(total1), 32'(a));
            chk("n1_in_ready_lo", 32'(in_ready1), 32'd0);
            @(negedge clk);
            chk("n1_out_valid_lo", 32'(out_valid1), 32'd0);
            chk("n1_in_ready", 32'(in_ready1), 32'd1);
            chk("n1_total_clr", 32'(total1), 32'd0);
        end
        iv1 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
